// File: rtl/nat_pkg.sv
// nat_pkg -- shared definitions for the NAT connection table.
// Holds the 104-bit key width, the tuple field offsets, the tx response
// status encoding, the hash slice offsets and the controller states.
package nat_pkg;

  localparam int KEY_W   = 104;
  localparam int IP_W    = 32;
  localparam int PORT_W  = 16;
  localparam int PROTO_W = 8;

  // Field offsets inside a 104-bit tuple (same positions for tx and rx tuples).
  localparam int OFF_IP_HI   = 72;
  localparam int OFF_IP_LO   = 40;
  localparam int OFF_PORT_HI = 24;
  localparam int OFF_PORT_LO = 8;
  localparam int OFF_PROTO   = 0;

  // Bit offsets of the slices XOR-folded into the table address.
  localparam int HOFF_0 = 0;
  localparam int HOFF_1 = 8;
  localparam int HOFF_2 = 24;
  localparam int HOFF_3 = 40;
  localparam int HOFF_4 = 72;

  typedef enum logic [1:0] {
    STAT_HIT  = 2'd0,
    STAT_NEW  = 2'd1,
    STAT_FAIL = 2'd2
  } conn_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_PROBE,
    S_RX_INSERT,
    S_RX_PROBE,
    S_RESP
  } nat_state_e;

  // Reorder an inbound tuple into the rx table key layout
  // {inner_ip, outer_ip, xlat_port, outer_port, proto}.
  function automatic logic [KEY_W-1:0] rx_key_from_rx(input logic [KEY_W-1:0] t);
    return {t[OFF_IP_LO +: IP_W], t[OFF_IP_HI +: IP_W],
            t[OFF_PORT_LO +: PORT_W], t[OFF_PORT_HI +: PORT_W],
            t[OFF_PROTO +: PROTO_W]};
  endfunction

endpackage

// File: rtl/nat_hash_fold.sv
// nat_hash_fold -- combinational table address hash.
// Ports:
//   i_key  [104]      key to hash
//   o_addr [HASH_LEN] XOR of the HASH_LEN-bit key slices at the package offsets
module nat_hash_fold
  import nat_pkg::*;
#(
  parameter int HASH_LEN = 6
) (
  input  logic [KEY_W-1:0]    i_key,
  output logic [HASH_LEN-1:0] o_addr
);

  assign o_addr = i_key[HOFF_0 +: HASH_LEN] ^ i_key[HOFF_1 +: HASH_LEN] ^
                  i_key[HOFF_2 +: HASH_LEN] ^ i_key[HOFF_3 +: HASH_LEN] ^
                  i_key[HOFF_4 +: HASH_LEN];

  // Key bits outside the folded slices deliberately do not affect the address.
  logic w_unused_key;
  assign w_unused_key = ^i_key;

endmodule

// File: rtl/nat_conn_table.sv
// nat_conn_table -- NAT connection table with linear-probe hashing.
// A tx lookup either hits an existing translation, allocates the next port
// (PORT_BASE + idx) and mirrors it into the rx table, or fails. An rx lookup
// maps a translated inbound tuple back to the original inner port.
// Ports:
//   clk, reset (sync, active low)
//   tx_tuple_data/valid/ready   outbound request
//   tx_conn_data/status/valid   outbound response (status HIT/NEW/FAIL)
//   rx_tuple_data/valid/ready   inbound request
//   rx_conn_data/hit/valid      inbound response
//   occupancy, table_full       live entry count and full flag
module nat_conn_table
  import nat_pkg::*;
#(
  parameter int          HASH_LEN  = 6,
  parameter int          MAX_PROBE = 8,
  parameter logic [15:0] PORT_BASE = 16'h4000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [127:0]      tx_tuple_data,
  input  logic              tx_tuple_valid,
  output logic              tx_tuple_ready,
  output logic [15:0]       tx_conn_data,
  output logic [1:0]        tx_conn_status,
  output logic              tx_conn_valid,
  input  logic [127:0]      rx_tuple_data,
  input  logic              rx_tuple_valid,
  output logic              rx_tuple_ready,
  output logic [15:0]       rx_conn_data,
  output logic              rx_conn_hit,
  output logic              rx_conn_valid,
  output logic [HASH_LEN:0] occupancy,
  output logic              table_full
);

  localparam int DEPTH = 1 << HASH_LEN;
  localparam int CNT_W = HASH_LEN + 1;

  nat_state_e r_state, w_state_nxt;

  logic [KEY_W-1:0]    r_tx_key, r_rx_key;
  logic [PORT_W-1:0]   r_rx_port;  // inner_port carried from the tx request into RX_INSERT
  logic [CNT_W-1:0]    r_probe;
  logic [DEPTH-1:0]    r_tx_vld, r_rx_vld;
  logic [KEY_W-1:0]    r_tx_tbl_key  [DEPTH];
  logic [HASH_LEN-1:0] r_tx_tbl_idx  [DEPTH];
  logic [KEY_W-1:0]    r_rx_tbl_key  [DEPTH];
  logic [PORT_W-1:0]   r_rx_tbl_port [DEPTH];

  logic [HASH_LEN-1:0] w_tx_hash, w_rx_hash, w_tx_addr, w_rx_addr;
  logic                w_tx_acc, w_rx_acc, w_probe_last;
  logic                w_tx_match, w_tx_empty, w_rx_match, w_rx_empty;
  logic [15:0]         w_new_port, w_hit_port;

  nat_hash_fold #(.HASH_LEN(HASH_LEN)) u_tx_hash (.i_key(r_tx_key), .o_addr(w_tx_hash));
  nat_hash_fold #(.HASH_LEN(HASH_LEN)) u_rx_hash (.i_key(r_rx_key), .o_addr(w_rx_hash));

  // Address arithmetic is HASH_LEN bits wide, so the probe wraps modulo DEPTH.
  assign w_tx_addr    = w_tx_hash + r_probe[HASH_LEN-1:0];
  assign w_rx_addr    = w_rx_hash + r_probe[HASH_LEN-1:0];
  assign w_probe_last = (r_probe == CNT_W'(MAX_PROBE - 1));

  assign w_tx_empty = !r_tx_vld[w_tx_addr];
  assign w_tx_match = r_tx_vld[w_tx_addr] && (r_tx_tbl_key[w_tx_addr] == r_tx_key);
  assign w_rx_empty = !r_rx_vld[w_rx_addr];
  assign w_rx_match = r_rx_vld[w_rx_addr] && (r_rx_tbl_key[w_rx_addr] == r_rx_key);

  // Idx values are issued in order, so the next idx is the current occupancy.
  assign w_new_port = PORT_BASE + 16'(occupancy[HASH_LEN-1:0]);
  assign w_hit_port = PORT_BASE + 16'(r_tx_tbl_idx[w_tx_addr]);

  // rx is held off while tx is offered so that tx wins the arbitration.
  assign tx_tuple_ready = reset && (r_state == S_IDLE);
  assign rx_tuple_ready = reset && (r_state == S_IDLE) && !tx_tuple_valid;
  assign w_tx_acc       = tx_tuple_valid && tx_tuple_ready;
  assign w_rx_acc       = rx_tuple_valid && rx_tuple_ready;

  // Occupancy never exceeds DEPTH, so its top bit alone marks a full table.
  assign table_full = occupancy[HASH_LEN];

  conn_status_e w_tx_stat;
  logic         w_tx_done, w_rx_done, w_rx_hit, w_tx_wr, w_rx_wr;
  logic [15:0]  w_tx_data, w_rx_data;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_done   = 1'b0;
    w_tx_stat   = STAT_FAIL;
    w_tx_data   = '0;
    w_tx_wr     = 1'b0;
    w_rx_done   = 1'b0;
    w_rx_hit    = 1'b0;
    w_rx_data   = '0;
    w_rx_wr     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_tx_acc)      w_state_nxt = S_TX_PROBE;
        else if (w_rx_acc) w_state_nxt = S_RX_PROBE;
      end
      S_TX_PROBE: begin
        if (w_tx_match) begin
          w_tx_done   = 1'b1;
          w_tx_stat   = STAT_HIT;
          w_tx_data   = w_hit_port;
          w_state_nxt = S_RESP;
        end else if (w_tx_empty && !table_full) begin
          w_tx_done   = 1'b1;
          w_tx_stat   = STAT_NEW;
          w_tx_data   = w_new_port;
          w_tx_wr     = 1'b1;
          w_state_nxt = S_RX_INSERT;
        end else if (w_tx_empty || w_probe_last) begin
          w_tx_done   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RX_INSERT: begin
        // An rx slot is always free here: both tables hold the same entry count.
        if (w_rx_empty) begin
          w_rx_wr     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RX_PROBE: begin
        if (w_rx_match) begin
          w_rx_done   = 1'b1;
          w_rx_hit    = 1'b1;
          w_rx_data   = r_rx_tbl_port[w_rx_addr];
          w_state_nxt = S_RESP;
        end else if (w_rx_empty || w_probe_last) begin
          w_rx_done   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_probe        <= '0;
      r_tx_vld       <= '0;
      r_rx_vld       <= '0;
      occupancy      <= '0;
      tx_conn_valid  <= 1'b0;
      tx_conn_data   <= '0;
      tx_conn_status <= '0;
      rx_conn_valid  <= 1'b0;
      rx_conn_data   <= '0;
      rx_conn_hit    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      // The probe index restarts on every state change and advances while probing.
      r_probe       <= (w_state_nxt == r_state) ? r_probe + 1'b1 : '0;
      tx_conn_valid <= w_tx_done;
      rx_conn_valid <= w_rx_done;
      if (w_tx_done) begin
        tx_conn_data   <= w_tx_data;
        tx_conn_status <= w_tx_stat;
      end
      if (w_rx_done) begin
        rx_conn_data <= w_rx_data;
        rx_conn_hit  <= w_rx_hit;
      end
      if (w_tx_wr) begin
        r_tx_vld[w_tx_addr] <= 1'b1;
        occupancy           <= occupancy + 1'b1;
      end
      if (w_rx_wr) r_rx_vld[w_rx_addr] <= 1'b1;
    end
  end

  // NOTE: key/payload storage is not reset; the cleared valid bits already mark every slot empty.
  always_ff @(posedge clk) begin
    if (w_tx_acc) begin
      r_tx_key  <= tx_tuple_data[KEY_W-1:0];
      r_rx_port <= tx_tuple_data[OFF_PORT_HI +: PORT_W];
    end
    if (w_rx_acc) begin
      r_rx_key <= rx_key_from_rx(rx_tuple_data[KEY_W-1:0]);
    end else if (w_tx_wr) begin
      r_rx_key <= {r_tx_key[OFF_IP_HI +: IP_W], r_tx_key[OFF_IP_LO +: IP_W], w_new_port,
                   r_tx_key[OFF_PORT_LO +: PORT_W], r_tx_key[OFF_PROTO +: PROTO_W]};
    end
    if (w_tx_wr) begin
      r_tx_tbl_key[w_tx_addr] <= r_tx_key;
      r_tx_tbl_idx[w_tx_addr] <= occupancy[HASH_LEN-1:0];
    end
    if (w_rx_wr) begin
      r_rx_tbl_key[w_rx_addr]  <= r_rx_key;
      r_rx_tbl_port[w_rx_addr] <= r_rx_port;
    end
  end

  // Tuple bits above the key are not part of any lookup.
  logic w_unused_hi;
  assign w_unused_hi = ^{tx_tuple_data[127:KEY_W], rx_tuple_data[127:KEY_W]};

endmodule

// File: tb/tb_nat_conn_table.sv
// tb_nat_conn_table -- directed bench for nat_conn_table.
// Three instances: default geometry, a 16-entry table with MAX_PROBE 16 for the
// full-table case, and a 16-entry table with MAX_PROBE 2 for probe exhaustion and wrap.
module tb_nat_conn_table;

  localparam logic [1:0] HIT = 2'd0, NEW = 2'd1, FAL = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       [3];
  logic [127:0] tx_data   [3];
  logic [127:0] rx_data   [3];
  logic         tx_valid  [3];
  logic         rx_valid  [3];
  logic         tx_ready  [3];
  logic         rx_ready  [3];
  logic         tx_cvalid [3];
  logic         rx_cvalid [3];
  logic         rx_chit   [3];
  logic         full      [3];
  logic [15:0]  tx_cdata  [3];
  logic [15:0]  rx_cdata  [3];
  logic [1:0]   tx_cstat  [3];
  logic [6:0]   occ0;
  logic [4:0]   occ1, occ2;

  int n_cmp = 0;
  int n_err = 0;

  nat_conn_table u_dut0 (
    .clk(clk), .reset(rst[0]),
    .tx_tuple_data(tx_data[0]), .tx_tuple_valid(tx_valid[0]), .tx_tuple_ready(tx_ready[0]),
    .tx_conn_data(tx_cdata[0]), .tx_conn_status(tx_cstat[0]), .tx_conn_valid(tx_cvalid[0]),
    .rx_tuple_data(rx_data[0]), .rx_tuple_valid(rx_valid[0]), .rx_tuple_ready(rx_ready[0]),
    .rx_conn_data(rx_cdata[0]), .rx_conn_hit(rx_chit[0]), .rx_conn_valid(rx_cvalid[0]),
    .occupancy(occ0), .table_full(full[0]));

  nat_conn_table #(.HASH_LEN(4), .MAX_PROBE(16)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .tx_tuple_data(tx_data[1]), .tx_tuple_valid(tx_valid[1]), .tx_tuple_ready(tx_ready[1]),
    .tx_conn_data(tx_cdata[1]), .tx_conn_status(tx_cstat[1]), .tx_conn_valid(tx_cvalid[1]),
    .rx_tuple_data(rx_data[1]), .rx_tuple_valid(rx_valid[1]), .rx_tuple_ready(rx_ready[1]),
    .rx_conn_data(rx_cdata[1]), .rx_conn_hit(rx_chit[1]), .rx_conn_valid(rx_cvalid[1]),
    .occupancy(occ1), .table_full(full[1]));

  nat_conn_table #(.HASH_LEN(4), .MAX_PROBE(2)) u_dut2 (
    .clk(clk), .reset(rst[2]),
    .tx_tuple_data(tx_data[2]), .tx_tuple_valid(tx_valid[2]), .tx_tuple_ready(tx_ready[2]),
    .tx_conn_data(tx_cdata[2]), .tx_conn_status(tx_cstat[2]), .tx_conn_valid(tx_cvalid[2]),
    .rx_tuple_data(rx_data[2]), .rx_tuple_valid(rx_valid[2]), .rx_tuple_ready(rx_ready[2]),
    .rx_conn_data(rx_cdata[2]), .rx_conn_hit(rx_chit[2]), .rx_conn_valid(rx_cvalid[2]),
    .occupancy(occ2), .table_full(full[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [103:0] txk(input logic [31:0] in_ip, input logic [31:0] out_ip,
                                       input logic [15:0] in_p, input logic [15:0] out_p,
                                       input logic [7:0] pr);
    return {in_ip, out_ip, in_p, out_p, pr};
  endfunction

  function automatic logic [127:0] rxt(input logic [31:0] out_ip, input logic [31:0] in_ip,
                                       input logic [15:0] out_p, input logic [15:0] xlat,
                                       input logic [7:0] pr);
    return {24'h0, out_ip, in_ip, out_p, xlat, pr};
  endfunction

  // Issue one tx request (called at a negedge) and check its response; elat < 0 skips latency.
  task automatic tx_req(input int d, input logic [103:0] key, input logic [1:0] est,
                        input logic [15:0] edata, input int elat, input string tag);
    int n;
    tx_data[d]  = {24'h0, key};
    tx_valid[d] = 1'b1;
    n = 0;
    while (!tx_ready[d] && n < 200) begin @(negedge clk); n++; end
    check({tag, "/accept"}, 32'(tx_ready[d]), 32'd1);
    @(negedge clk);
    tx_valid[d] = 1'b0;
    n = 1;
    while (!tx_cvalid[d] && n < 40) begin @(negedge clk); n++; end
    check({tag, "/valid"}, 32'(tx_cvalid[d]), 32'd1);
    if (elat >= 0) check({tag, "/lat"}, 32'(n), 32'(elat));
    check({tag, "/status"}, 32'(tx_cstat[d]), 32'(est));
    check({tag, "/data"}, 32'(tx_cdata[d]), 32'(edata));
    @(negedge clk);
    check({tag, "/strobe"}, 32'(tx_cvalid[d]), 32'd0);
  endtask

  task automatic rx_req(input int d, input logic [127:0] tup, input logic ehit,
                        input logic [15:0] edata, input int elat, input string tag);
    int n;
    rx_data[d]  = tup;
    rx_valid[d] = 1'b1;
    n = 0;
    while (!rx_ready[d] && n < 200) begin @(negedge clk); n++; end
    check({tag, "/accept"}, 32'(rx_ready[d]), 32'd1);
    @(negedge clk);
    rx_valid[d] = 1'b0;
    n = 1;
    while (!rx_cvalid[d] && n < 40) begin @(negedge clk); n++; end
    check({tag, "/valid"}, 32'(rx_cvalid[d]), 32'd1);
    if (elat >= 0) check({tag, "/lat"}, 32'(n), 32'(elat));
    check({tag, "/hit"}, 32'(rx_chit[d]), 32'(ehit));
    check({tag, "/data"}, 32'(rx_cdata[d]), 32'(edata));
    @(negedge clk);
    check({tag, "/strobe"}, 32'(rx_cvalid[d]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [103:0] k1, k2, k3, k4, kc;
    int tx_at, rx_at, seen;
    logic drop_rx;
    logic [1:0]  a_st;
    logic [15:0] a_tx, a_rx;
    logic        a_hit;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; tx_valid[i] = 1'b0; rx_valid[i] = 1'b0;
      tx_data[i] = '0; rx_data[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst/tx_ready_low", 32'(tx_ready[0]), 32'd0);
    check("rst/rx_ready_low", 32'(rx_ready[0]), 32'd0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    @(negedge clk);
    check("init/tx_ready", 32'(tx_ready[0]), 32'd1);
    check("init/occ", 32'(occ0), 32'd0);
    check("init/full", 32'(full[0]), 32'd0);
    check("init/tx_valid", 32'(tx_cvalid[0]), 32'd0);
    check("init/tx_data", 32'(tx_cdata[0]), 32'd0);
    check("init/rx_valid", 32'(rx_cvalid[0]), 32'd0);

    // Basic allocate / hit and reverse lookup on the default instance.
    k1 = txk(32'h0A000002, 32'h08080808, 16'h1234, 16'h0050, 8'h06);
    tx_req(0, k1, NEW, 16'h4000, 2, "t1_new");
    tx_req(0, k1, HIT, 16'h4000, 2, "t1_hit");
    check("t1/occ", 32'(occ0), 32'd1);
    rx_req(0, rxt(32'h08080808, 32'h0A000002, 16'h0050, 16'h4000, 8'h06), 1'b1, 16'h1234, 2, "r1_hit");
    rx_req(0, rxt(32'h08080808, 32'h0A000002, 16'h0050, 16'h4001, 8'h06), 1'b0, 16'h0000, -1, "r1_miss");

    // Proto bit 6 lies outside every hash slice, so k2 collides with k1.
    k2 = txk(32'h0A000002, 32'h08080808, 16'h1234, 16'h0050, 8'h46);
    tx_req(0, k2, NEW, 16'h4001, 3, "t2_coll");
    tx_req(0, k2, HIT, 16'h4001, 3, "t2_hit");
    rx_req(0, rxt(32'h08080808, 32'h0A000002, 16'h0050, 16'h4001, 8'h46), 1'b1, 16'h1234, -1, "r2_hit");

    // tx and rx offered together: tx must be served first.
    k3 = txk(32'h0A000003, 32'h01020304, 16'h2222, 16'h0443, 8'h11);
    tx_data[0] = {24'h0, k3};
    rx_data[0] = rxt(32'h08080808, 32'h0A000002, 16'h0050, 16'h4000, 8'h06);
    tx_valid[0] = 1'b1;
    rx_valid[0] = 1'b1;
    #1;
    check("arb/tx_ready", 32'(tx_ready[0]), 32'd1);
    check("arb/rx_ready", 32'(rx_ready[0]), 32'd0);
    tx_at = -1; rx_at = -1; drop_rx = 1'b0;
    a_st = '0; a_tx = '0; a_rx = '0; a_hit = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      tx_valid[0] = 1'b0;
      if (drop_rx) rx_valid[0] = 1'b0;
      if (tx_cvalid[0] && tx_at < 0) begin tx_at = c; a_st = tx_cstat[0]; a_tx = tx_cdata[0]; end
      if (rx_cvalid[0] && rx_at < 0) begin rx_at = c; a_hit = rx_chit[0]; a_rx = rx_cdata[0]; end
      if (rx_valid[0] && rx_ready[0]) drop_rx = 1'b1;
    end
    rx_valid[0] = 1'b0;
    check("arb/tx_seen", 32'(tx_at > 0), 32'd1);
    check("arb/rx_after_tx", 32'(rx_at > tx_at), 32'd1);
    check("arb/tx_status", 32'(a_st), 32'(NEW));
    check("arb/tx_data", 32'(a_tx), 32'h4002);
    check("arb/rx_hit", 32'(a_hit), 32'd1);
    check("arb/rx_data", 32'(a_rx), 32'h1234);

    // Reset in the middle of a tx probe drops the request and clears the tables.
    k4 = txk(32'h0A000004, 32'h05050505, 16'h3333, 16'h0035, 8'h11);
    tx_data[0] = {24'h0, k4};
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    rst[0] = 1'b0;
    #1;
    check("rstmid/tx_ready_low", 32'(tx_ready[0]), 32'd0);
    seen = 0;
    @(negedge clk);
    if (tx_cvalid[0]) seen = 1;
    rst[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (tx_cvalid[0]) seen = 1;
    end
    check("rstmid/no_resp", 32'(seen), 32'd0);
    check("rstmid/occ", 32'(occ0), 32'd0);
    check("rstmid/tx_data", 32'(tx_cdata[0]), 32'd0);
    check("rstmid/tx_status", 32'(tx_cstat[0]), 32'd0);
    check("rstmid/rx_hit", 32'(rx_chit[0]), 32'd0);
    check("rstmid/rx_data", 32'(rx_cdata[0]), 32'd0);
    tx_req(0, k1, NEW, 16'h4000, 2, "rstmid_new");

    // Fill a 16-entry table; the 17th distinct tuple probes all 16 slots and fails.
    for (int k = 0; k < 16; k++)
      tx_req(1, txk(32'hC0A80001, 32'h01010101, 16'(k), 16'd80, 8'd17), NEW,
             16'h4000 + 16'(k), -1, $sformatf("fill%0d", k));
    check("fill/full", 32'(full[1]), 32'd1);
    check("fill/occ", 32'(occ1), 32'd16);
    tx_req(1, txk(32'hC0A80001, 32'h01010101, 16'd100, 16'd80, 8'd17), FAL, 16'h0000, 17, "fill_17th");
    check("fill/occ_after", 32'(occ1), 32'd16);
    tx_req(1, txk(32'hC0A80001, 32'h01010101, 16'd5, 16'd80, 8'd17), HIT, 16'h4005, -1, "fill_hit5");

    // MAX_PROBE 2: all keys hash to slot 15, the second wraps to slot 0, the third fails.
    kc = txk(32'h0, 32'h0, 16'h1230, 16'h0, 8'h0F);
    tx_req(2, kc, NEW, 16'h4000, 2, "wrap_a");
    kc = txk(32'h0, 32'h0, 16'h1230, 16'h0, 8'h1F);
    tx_req(2, kc, NEW, 16'h4001, 3, "wrap_b");
    tx_req(2, txk(32'h0, 32'h0, 16'h1230, 16'h0, 8'h2F), FAL, 16'h0000, 3, "wrap_c");
    tx_req(2, kc, HIT, 16'h4001, 3, "wrap_b_hit");
    check("wrap/occ", 32'(occ2), 32'd2);
    rx_req(2, rxt(32'h0, 32'h0, 16'h0, 16'h4001, 8'h1F), 1'b1, 16'h1230, 2, "wrap_rx_b");
    rx_req(2, rxt(32'h0, 32'h0, 16'h0, 16'h4000, 8'h0F), 1'b1, 16'h1230, 2, "wrap_rx_a");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nat_conn_table.md
NAT_CONN_TABLE -- requirements
Module: nat_conn_table

Interface
REQ-001 SHALL have parameter HASH_LEN, default 6, giving log2 table depth (DEPTH = 2^HASH_LEN, HASH_LEN 4..10).
REQ-002 SHALL have parameter MAX_PROBE, default 8, giving the maximum linear-probe steps per tx lookup or rx lookup (1..DEPTH).
REQ-003 SHALL have parameter PORT_BASE, default 16'h4000, giving the first translated port.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have port tx_tuple_data, input, 128, outbound tuple: [103:72] inner_ip, [71:40] outer_ip, [39:24] inner_port, [23:8] outer_port, [7:0] proto; [127:104] ignored.
REQ-007 SHALL have ports tx_tuple_valid (input, 1) and tx_tuple_ready (output, 1), the tx request handshake.
REQ-008 SHALL have port tx_conn_data, output, 16, the translated port.
REQ-009 SHALL have port tx_conn_status, output, 2, with values 0 HIT, 1 NEW, 2 FAIL.
REQ-010 SHALL have port tx_conn_valid, output, 1, a one-cycle tx response strobe.
REQ-011 SHALL have port rx_tuple_data, input, 128, inbound tuple: [103:72] outer_ip, [71:40] inner_ip, [39:24] outer_port, [23:8] xlat_port, [7:0] proto.
REQ-012 SHALL have ports rx_tuple_valid (input, 1) and rx_tuple_ready (output, 1), the rx request handshake.
REQ-013 SHALL have ports rx_conn_data (output, 16, original inner_port), rx_conn_hit (output, 1) and rx_conn_valid (output, 1, one-cycle strobe).
REQ-014 SHALL have ports occupancy (output, HASH_LEN+1, live entry count) and table_full (output, 1, asserted when occupancy == DEPTH).

Function
REQ-015 Tables: tx table {valid, 104-bit key, HASH_LEN-bit idx}; rx table {valid, 104-bit key {inner_ip, outer_ip, xlat_port, outer_port, proto}, 16-bit inner_port}. An entry is empty iff its valid bit is clear; an all-zero key is legal.
REQ-016 Hash = XOR of the HASH_LEN-bit slices at bit offsets 0, 8, 24, 40, 72 of the 104-bit key. The probe address wraps modulo DEPTH.
REQ-017 FSM states: IDLE, TX_PROBE, RX_INSERT, RX_PROBE, RESP. Both ready outputs are high only in IDLE.
REQ-018 In IDLE, tx wins when both valids are high. The losing rx request stays pending until ready is seen again.
REQ-019 TX accept at cycle 0; probe p (0-based) occurs in cycle 1+p; the response is valid in cycle 2+p.
REQ-020 TX key match -> HIT, tx_conn_data = PORT_BASE + stored idx, return to IDLE.
REQ-021 TX empty slot with table_full low -> write the entry with idx = occupancy, respond NEW with PORT_BASE + idx, increment occupancy, enter RX_INSERT.
REQ-022 TX after MAX_PROBE probes without match/empty, or empty slot while table_full -> FAIL, tx_conn_data = 0, no write.
REQ-023 RX_INSERT starts at hash(rx key with xlat_port = PORT_BASE + idx) and probes up to DEPTH slots to the first empty slot (guaranteed to exist), writes the entry, then returns to IDLE. tx_tuple_ready and rx_tuple_ready stay low throughout.
REQ-024 RX_PROBE uses the same timing as REQ-019. On a match: hit = 1, data = stored inner_port. On an empty slot or MAX_PROBE exhausted: hit = 0, data = 0.
REQ-025 Outputs are registered. The valid strobes are 0 in every cycle other than the response cycle; data and status hold their last value otherwise.
REQ-026 PORT_BASE + idx SHALL be computed as a 16-bit sum, zero-extending idx, with wrap discarded.
REQ-027 There is no deletion; the idx values issued are 0..DEPTH-1 in order.

Reset
REQ-028 While reset is low at a clock edge, the block SHALL: enter IDLE; clear all valid bits in both tables; set occupancy to 0; drive tx_conn_valid and rx_conn_valid to 0; drive tx_conn_data, tx_conn_status, rx_conn_data and rx_conn_hit to 0.
REQ-029 A request in flight when reset is asserted SHALL be dropped with no response. Both ready outputs are 0 while reset is low.

Structure
REQ-030 The shared package nat_pkg SHALL hold the key width 104, the field offsets, the status enum (HIT, NEW, FAIL) and the hash slice offsets.
REQ-031 A combinational sub-module nat_hash_fold (parameter HASH_LEN, 104-bit key in, HASH_LEN-bit address out) SHALL be instantiated for the tx path and the rx path.

Verification
REQ-032 Scenario: after reset, tx 0A000002/08080808/1234/0050/06 -> NEW, 4000 at cycle 2; repeating the same tuple -> HIT, 4000, occupancy 1.
REQ-033 Scenario: rx 08080808/0A000002/0050/4000/06 after REQ-032 -> hit = 1, data 1234. With xlat_port 4001 -> hit = 0, data 0.
REQ-034 Scenario: two tx tuples with equal hash -> second reply NEW 4001, with valid in cycle 3 (one extra probe).
REQ-035 Scenario: HASH_LEN = 4, MAX_PROBE = 16, 16 distinct tuples -> table_full = 1. A 17th distinct tuple -> FAIL, occupancy stays 16.
REQ-036 Scenario: MAX_PROBE = 2, three colliding tuples occupying hash h, h+1 -> third reply FAIL. A collision at slot DEPTH-1 wraps to slot 0.
REQ-037 Scenario: tx and rx valid in the same cycle -> tx served first, rx served after. Reset pulsed during TX_PROBE -> no response, occupancy 0, and the same tuple afterwards -> NEW 4000.
